pb_event_arbiter: RTL and testbench
===================================

# pb_event_arbiter

Turns a bank of debounced pushbuttons into one stream of discrete button events. It detects each press, optionally generates auto-repeat events while a button is held, and queues one pending event per button. A round-robin arbiter then presents those events one at a time on a valid/ready interface. It sits between the per-button debouncers and the lab's command/menu FSM.

## Interface

Parameters:
- NBTN, 4, number of buttons (2..16)
- HOLD_CYCLES, 50_000_000, held cycles after the press before the first repeat (≥2)
- REPEAT_CYCLES, 10_000_000, cycles between subsequent repeats (≥2)
- IDW, $clog2(NBTN), width of ev_id

Ports:
- clk  input  1  system clock, all logic on posedge
- rst  input  1  reset, asynchronous and active-high
- pb_db  input  NBTN  debounced button levels, synchronous to clk
- repeat_en  input  NBTN  per-button auto-repeat enable
- ev_valid  output  1  event offered
- ev_ready  input  1  consumer accepts event
- ev_id  output  IDW  button index of the offered event
- ev_repeat  output  1  0 = press event, 1 = auto-repeat event
- ovr  output  NBTN  sticky per-button overrun flags
- ovr_clr  input  1  synchronous clear of all ovr bits

## Operation

- **Reset (async, rst=1):** all of the following go to 0: pb_prev, pend, pend_rpt, hold counters, ovr, ev_valid, ev_id, ev_repeat. State is IDLE. The rr_last pointer goes to NBTN-1, so button 0 has first priority.
- **Press detect:** press[i] = pb_db[i] & ~pb_prev[i]. pb_prev <= pb_db every cycle.
- **Hold counter (per button):**
  - Cleared on press.
  - Cleared on any cycle with pb_db[i]=0.
  - Otherwise increments while pb_db[i]=1.
  - Let P be the press cycle. Repeat events fire at P+HOLD_CYCLES, then every REPEAT_CYCLES after that, only while pb_db[i] stays 1 and repeat_en[i]=1.
  - If repeat_en[i]=0, no repeats fire, but counting continues.
  - Counter width is $clog2(max(HOLD_CYCLES,REPEAT_CYCLES)+1) bits. After each repeat it reloads to the repeat phase and never wraps.
- **Release:** any cycle with pb_db[i]=0 cancels repeat timing. Already-pending events stay pending.
- **Pending slot (per button):**
  - A new event (press or repeat) sets pend[i] and writes pend_rpt[i] (0 for press, 1 for repeat).
  - If pend[i] is already 1 and is not being granted that cycle, the new event is dropped, the old event is kept, and ovr[i] <= 1.
  - Grant clears pend[i]. If an event for the same button arrives in the grant cycle, set wins: pend[i] stays 1 with the new kind, and there is no overrun.
- **ovr:** sticky. ovr_clr clears all bits. If a set and ovr_clr occur in the same cycle, set wins.
- **Arbiter FSM:**
  - IDLE:
    - If no pend bit is set, stay in IDLE.
    - If any pend bit is set, grant the first set index in order rr_last+1, rr_last+2, … (mod NBTN).
    - On grant: ev_id <= index, ev_repeat <= pend_rpt[index], ev_valid <= 1, clear pend[index], rr_last <= index, go to OFFER.
  - OFFER:
    - ev_id and ev_repeat are held stable and ev_valid stays 1 until ev_valid & ev_ready.
    - On handshake: ev_valid <= 0, go to IDLE.
  - A valid never drops without a handshake; only reset can abort an offer.
- **Reset mid-offer:** the event is discarded. ev_valid falls asynchronously.

## Timing

- Press latency: pb_db rises and is first sampled at edge k (press cycle). pend is set at edge k+1, and ev_valid is 1 after edge k+2 if the FSM is IDLE and the button wins arbitration.
- Handshake at edge h (ev_valid=ev_ready=1) gives ev_valid=0 after h. The next grant occurs at edge h+1, so the minimum spacing is 2 cycles per event.
- ev_ready is ignored while ev_valid=0.
- Outputs are all registered; there is no combinational path from ev_ready to ev_valid.

## Test plan

- **Single press:** NBTN=4. Raise pb_db[2] for 5 cycles with ev_ready=1. Expect exactly one event {id=2, repeat=0}, ev_valid high 1 cycle, 2 cycles after the press sample, and ovr=0.
- **Simultaneous presses:** pb_db[0] and pb_db[3] rise in the same cycle, ev_ready=1. Expect the order id 0 then id 3, 2 cycles apart. Then press 0 and 1 together: expect order 0 then 1 (rr_last=3 wraps to 0).
- **Auto-repeat:** HOLD_CYCLES=8, REPEAT_CYCLES=4, repeat_en[1]=1. Hold pb_db[1] for 20 cycles from press cycle P. Expect events: press at P, repeats originating at P+8, P+12, P+16, none after release. Repeat the test with repeat_en[1]=0: expect only the press event.
- **Backpressure and overrun:** ev_ready=0. Press button 0, release, then press again twice. Expect ev_valid held with id=0, one event pending, ovr[0]=1. Raise ev_ready: expect exactly 2 events total. Pulse ovr_clr: expect ovr=0.
- **Set/clear collision:** arrange a repeat for button 2 to occur in the same cycle pend[2] is granted. Expect pend[2] to remain 1, a second event {id=2, repeat=1} to follow, and ovr[2]=0.
- **Async reset:** assert rst mid-OFFER between clock edges. Expect ev_valid=0 immediately. After release, no stale event is offered, and button 0 has first priority.

Source files
------------

// File: rtl/pb_event_arbiter.sv
// Pushbutton event source: press and auto-repeat detection, one pending slot per button,
// and a round-robin valid/ready presenter. Press-to-valid is 2 cycles; a held offer stalls grants.
module pb_event_arbiter #(
  parameter int NBTN          = 4,
  parameter int HOLD_CYCLES   = 50_000_000,
  parameter int REPEAT_CYCLES = 10_000_000,
  parameter int IDW           = $clog2(NBTN)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NBTN-1:0] pb_db,
  input  logic [NBTN-1:0] repeat_en,
  output logic            ev_valid,
  input  logic            ev_ready,
  output logic [IDW-1:0]  ev_id,
  output logic            ev_repeat,
  output logic [NBTN-1:0] ovr,
  input  logic            ovr_clr
);

  localparam int MAXC = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);
  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] RPT_LAST  = CW'(REPEAT_CYCLES - 1);

  typedef enum logic {IDLE, OFFER} state_t;

  state_t          state;
  logic [IDW-1:0]  rr_last;
  logic [NBTN-1:0] pb_prev;
  logic [NBTN-1:0] press;
  logic [NBTN-1:0] rpt_fire;
  logic [NBTN-1:0] phase;
  logic [NBTN-1:0] ev_new;
  logic [NBTN-1:0] ev_new_rpt;
  logic [NBTN-1:0] pend;
  logic [NBTN-1:0] pend_rpt;
  logic [NBTN-1:0] gnt_vec;
  logic [NBTN-1:0] ovr_set;
  logic [CW-1:0]   cnt [NBTN];
  logic            gnt_any;
  logic [IDW-1:0]  gnt_idx;

  assign press = pb_db & ~pb_prev;

  // phase=0 times the initial hold, phase=1 the repeat interval; each fire restarts the count
  always_comb begin
    rpt_fire = '0;
    for (int i = 0; i < NBTN; i++) begin
      rpt_fire[i] = pb_db[i] & ~press[i] & (cnt[i] == (phase[i] ? RPT_LAST : HOLD_LAST));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pb_prev    <= '0;
      phase      <= '0;
      ev_new     <= '0;
      ev_new_rpt <= '0;
      for (int i = 0; i < NBTN; i++) cnt[i] <= '0;
    end else begin
      pb_prev    <= pb_db;
      ev_new     <= press | (rpt_fire & repeat_en);
      ev_new_rpt <= rpt_fire & repeat_en;
      for (int i = 0; i < NBTN; i++) begin
        if (!pb_db[i] || press[i]) begin
          cnt[i]   <= '0;
          phase[i] <= 1'b0;
        end else if (rpt_fire[i]) begin
          cnt[i]   <= '0;
          phase[i] <= 1'b1;
        end else begin
          cnt[i] <= cnt[i] + CW'(1);
        end
      end
    end
  end

  always_comb begin
    int c;
    logic [IDW-1:0] idx;
    gnt_any = 1'b0;
    gnt_idx = '0;
    for (int k = 1; k <= NBTN; k++) begin
      c = int'(rr_last) + k;
      if (c >= NBTN) c = c - NBTN;
      idx = IDW'(c);
      if (!gnt_any && pend[idx]) begin
        gnt_any = 1'b1;
        gnt_idx = idx;
      end
    end
  end

  always_comb begin
    gnt_vec = '0;
    if (state == IDLE && gnt_any) gnt_vec[gnt_idx] = 1'b1;
  end

  // An event arriving while its slot is occupied and not leaving is dropped
  assign ovr_set = ev_new & pend & ~gnt_vec;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend     <= '0;
      pend_rpt <= '0;
      ovr      <= '0;
    end else begin
      for (int i = 0; i < NBTN; i++) begin
        if (ev_new[i] && !ovr_set[i]) begin
          pend[i]     <= 1'b1;
          pend_rpt[i] <= ev_new_rpt[i];
        end else if (gnt_vec[i]) begin
          pend[i] <= 1'b0;
        end
      end
      ovr <= (ovr_clr ? '0 : ovr) | ovr_set;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      ev_valid  <= 1'b0;
      ev_id     <= '0;
      ev_repeat <= 1'b0;
      rr_last   <= IDW'(NBTN - 1);
    end else begin
      case (state)
        IDLE: begin
          if (gnt_any) begin
            ev_id     <= gnt_idx;
            ev_repeat <= pend_rpt[gnt_idx];
            ev_valid  <= 1'b1;
            rr_last   <= gnt_idx;
            state     <= OFFER;
          end
        end
        OFFER: begin
          if (ev_ready) begin
            ev_valid <= 1'b0;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pb_event_arbiter.sv
// Directed bench for pb_event_arbiter with short hold/repeat timing.
module tb_pb_event_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] pb_db = '0;
  logic [3:0] repeat_en = '0;
  logic       ev_valid;
  logic       ev_ready = 1'b0;
  logic [1:0] ev_id;
  logic       ev_repeat;
  logic [3:0] ovr;
  logic       ovr_clr = 1'b0;

  int checks = 0;
  int errors = 0;
  int hs_cnt = 0;
  int hs_base = 0;

  pb_event_arbiter #(
    .NBTN(4), .HOLD_CYCLES(8), .REPEAT_CYCLES(4)
  ) dut (
    .clk(clk), .rst(rst), .pb_db(pb_db), .repeat_en(repeat_en),
    .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_id(ev_id), .ev_repeat(ev_repeat),
    .ovr(ovr), .ovr_clr(ovr_clr)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (ev_valid && ev_ready) hs_cnt <= hs_cnt + 1;

  initial begin
    #100000;
    $display("FAIL timeout");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    pb_db = '0;
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    hs_base = hs_cnt;
  endtask

  initial begin
    logic exp_v;
    logic exp_r;

    // reset state
    #2 rst = 1'b1;
    #1;
    chk("rst_valid", ev_valid, 0);
    chk("rst_id", ev_id, 0);
    chk("rst_repeat", ev_repeat, 0);
    chk("rst_ovr", ovr, 0);
    tick(2);
    rst = 1'b0;
    tick();
    chk("rst_release_valid", ev_valid, 0);

    // single press of button 2
    ev_ready = 1'b1;
    hs_base = hs_cnt;
    pb_db = 4'b0100;
    tick(); chk("t1_k0_valid", ev_valid, 0);
    tick(); chk("t1_k1_valid", ev_valid, 0);
    tick(); chk("t1_k2_valid", ev_valid, 1);
    chk("t1_k2_id", ev_id, 2);
    chk("t1_k2_repeat", ev_repeat, 0);
    tick(); chk("t1_k3_valid", ev_valid, 0);
    tick(); pb_db = '0;
    tick(6);
    chk("t1_events", hs_cnt - hs_base, 1);
    chk("t1_ovr", ovr, 0);

    // simultaneous presses and round-robin wrap
    do_reset();
    ev_ready = 1'b1;
    pb_db = 4'b1001;
    tick(3); chk("t2a_first_valid", ev_valid, 1); chk("t2a_first_id", ev_id, 0);
    tick(); chk("t2a_gap_valid", ev_valid, 0);
    tick(); chk("t2a_second_valid", ev_valid, 1); chk("t2a_second_id", ev_id, 3);
    tick(); chk("t2a_end_valid", ev_valid, 0);
    pb_db = '0;
    tick(3);
    pb_db = 4'b0011;
    tick(3); chk("t2b_first_valid", ev_valid, 1); chk("t2b_first_id", ev_id, 0);
    tick(); chk("t2b_gap_valid", ev_valid, 0);
    tick(); chk("t2b_second_valid", ev_valid, 1); chk("t2b_second_id", ev_id, 1);
    pb_db = '0;
    tick(4);
    chk("t2_events", hs_cnt - hs_base, 4);

    // auto-repeat on button 1: press at P, repeats from P+8, P+12, P+16
    do_reset();
    ev_ready = 1'b1;
    repeat_en = 4'b0010;
    pb_db = 4'b0010;
    for (int t = 0; t < 30; t++) begin
      tick();
      exp_v = (t == 2) || (t == 10) || (t == 14) || (t == 18);
      chk($sformatf("t3_en_valid_%0d", t), ev_valid, exp_v);
      if (exp_v) begin
        chk($sformatf("t3_en_id_%0d", t), ev_id, 1);
        chk($sformatf("t3_en_repeat_%0d", t), ev_repeat, (t != 2));
      end
      if (t == 19) pb_db = '0;
    end
    chk("t3_en_events", hs_cnt - hs_base, 4);

    repeat_en = '0;
    hs_base = hs_cnt;
    pb_db = 4'b0010;
    for (int t = 0; t < 30; t++) begin
      tick();
      exp_v = (t == 2);
      chk($sformatf("t3_dis_valid_%0d", t), ev_valid, exp_v);
      if (t == 19) pb_db = '0;
    end
    chk("t3_dis_events", hs_cnt - hs_base, 1);

    // backpressure and overrun on button 0
    do_reset();
    ev_ready = 1'b0;
    pb_db = 4'b0001;
    tick(3); chk("t4_offer_valid", ev_valid, 1); chk("t4_offer_id", ev_id, 0);
    pb_db = '0;     tick();
    pb_db = 4'b0001; tick();
    pb_db = '0;     tick();
    pb_db = 4'b0001; tick();
    pb_db = '0;     tick(3);
    chk("t4_held_valid", ev_valid, 1);
    chk("t4_held_id", ev_id, 0);
    chk("t4_ovr_set", ovr, 4'b0001);
    ev_ready = 1'b1;
    tick(); chk("t4_hs1_valid", ev_valid, 0);
    tick(); chk("t4_next_valid", ev_valid, 1); chk("t4_next_id", ev_id, 0); chk("t4_next_repeat", ev_repeat, 0);
    tick(); chk("t4_hs2_valid", ev_valid, 0);
    tick(4);
    chk("t4_events", hs_cnt - hs_base, 2);
    chk("t4_ovr_sticky", ovr, 4'b0001);
    ovr_clr = 1'b1; tick(); ovr_clr = 1'b0;
    chk("t4_ovr_clr", ovr, 0);
    tick(); chk("t4_ovr_stays_clr", ovr, 0);

    // repeat for button 2 lands in the cycle its pending slot is granted
    do_reset();
    ev_ready = 1'b0;
    repeat_en = 4'b0100;
    pb_db = 4'b0100;
    for (int t = 0; t < 21; t++) begin
      tick();
      exp_v = (t >= 2 && t <= 11) || (t == 13) || (t == 15);
      exp_r = (t >= 13);
      chk($sformatf("t5_valid_%0d", t), ev_valid, exp_v);
      if (exp_v) begin
        chk($sformatf("t5_id_%0d", t), ev_id, 2);
        chk($sformatf("t5_repeat_%0d", t), ev_repeat, exp_r);
      end
      chk($sformatf("t5_ovr_%0d", t), ovr, 0);
      if (t == 11) ev_ready = 1'b1;
      if (t == 13) pb_db = '0;
    end
    chk("t5_events", hs_cnt - hs_base, 3);
    repeat_en = '0;

    // async reset during an offer
    do_reset();
    ev_ready = 1'b0;
    pb_db = 4'b1010;
    tick(3); chk("t6_offer_valid", ev_valid, 1); chk("t6_offer_id", ev_id, 1);
    pb_db = '0;
    tick();
    #2 rst = 1'b1;
    #1 chk("t6_async_valid", ev_valid, 0);
    tick(2);
    rst = 1'b0;
    ev_ready = 1'b1;
    hs_base = hs_cnt;
    tick(6);
    chk("t6_no_stale_valid", ev_valid, 0);
    chk("t6_no_stale_events", hs_cnt - hs_base, 0);
    pb_db = 4'b1001;
    tick(3); chk("t6_first_valid", ev_valid, 1); chk("t6_first_id", ev_id, 0);
    tick(); chk("t6_gap_valid", ev_valid, 0);
    tick(); chk("t6_second_valid", ev_valid, 1); chk("t6_second_id", ev_id, 3);
    pb_db = '0;
    tick(3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
